// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache refill path
// (read-only) and the D-cache refill/writeback path (read/write).
// One requester is granted at a time. Its request is latched and issued to
// memory. Write beats are then streamed to memory, or read beats are routed
// back to the owner, until the transaction's last beat.
// Optional feature: define ARB_RR_EN for round-robin arbitration on a tie.
// Without it, D-side has fixed priority over I-side.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ic_req_valid,
    output logic                    ic_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
    output logic                    ic_resp_valid,
    output logic                    ic_resp_last,
    input  logic                    dc_req_valid,
    output logic                    dc_req_ready,
    input  logic                    dc_req_rw,
    input  logic [ADDR_WIDTH-1:0]   dc_req_addr,
    input  logic                    dc_wdata_valid,
    output logic                    dc_wdata_ready,
    input  logic [DATA_WIDTH-1:0]   dc_wdata,
    input  logic [DATA_WIDTH/8-1:0] dc_wmask,
    output logic                    dc_resp_valid,
    output logic                    dc_resp_last,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_data_valid,
    input  logic                    mem_req_data_ready,
    output logic [DATA_WIDTH-1:0]   mem_req_data_bits,
    output logic [DATA_WIDTH/8-1:0] mem_req_data_mask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Owner / last_grant encoding
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RRESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_grant_q, last_grant_d;

    logic idle_ok;
    logic pick_d;
    logic at_last;
    logic in_wdata;
    logic in_rresp;
    logic wbeat_fire;
    logic rbeat_fire;

    // Arbitration: choose the winner among the valid requesters in IDLE
    always_comb begin
`ifdef ARB_RR_EN
        // On a tie the side that did not win the previous grant goes first
        pick_d = dc_req_valid && (!ic_req_valid || (last_grant_q == OWNER_I));
`else
        pick_d = dc_req_valid;
`endif
    end

`ifndef ARB_RR_EN
    // last_grant is still tracked in the fixed-priority build, just not consulted
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Handshake and datapath routing derived from the current state
    always_comb begin
        // Readies stay low while reset is held, even though the state is already IDLE
        idle_ok            = (state_q == IDLE) && reset_n;
        in_wdata           = (state_q == WDATA);
        in_rresp           = (state_q == RRESP);
        at_last            = (cnt_q == LAST_BEAT);

        ic_req_ready       = idle_ok && ic_req_valid && !pick_d;
        dc_req_ready       = idle_ok && pick_d;

        mem_req_valid      = (state_q == REQ);
        mem_req_rw         = rw_q;
        mem_req_addr       = addr_q;

        mem_req_data_valid = in_wdata && dc_wdata_valid;
        dc_wdata_ready     = in_wdata && mem_req_data_ready;
        mem_req_data_bits  = dc_wdata;
        mem_req_data_mask  = dc_wmask;
        wbeat_fire         = mem_req_data_valid && mem_req_data_ready;

        // Memory beats outside RRESP are dropped
        rbeat_fire         = in_rresp && mem_resp_valid;
        ic_resp_valid      = rbeat_fire && (owner_q == OWNER_I);
        dc_resp_valid      = rbeat_fire && (owner_q == OWNER_D);
        ic_resp_last       = ic_resp_valid && at_last;
        dc_resp_last       = dc_resp_valid && at_last;
        resp_data          = in_rresp ? mem_resp_data : '0;
    end

    // Next-state logic: grant, issue, then count beats to the end of the transaction
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (ic_req_ready || dc_req_ready) begin
                    owner_d      = dc_req_ready ? OWNER_D : OWNER_I;
                    rw_d         = dc_req_ready && dc_req_rw;
                    addr_d       = dc_req_ready ? dc_req_addr : ic_req_addr;
                    last_grant_d = dc_req_ready ? OWNER_D : OWNER_I;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = rw_q ? WDATA : RRESP;
                end
            end
            WDATA: begin
                if (wbeat_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (at_last) state_d = IDLE;
                end
            end
            RRESP: begin
                if (rbeat_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (at_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_I;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= OWNER_D;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle table for the first I-side
// read, then directed sequences for writes, arbitration, stray beats,
// mid-transaction reset and a BEATS=1 instance.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ic_req_valid, ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_valid, ic_resp_last;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic          dc_wdata_valid, dc_wdata_ready;
    logic [DW-1:0] dc_wdata;
    logic [MW-1:0] dc_wmask;
    logic          dc_resp_valid, dc_resp_last;
    logic [DW-1:0] resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    // Second instance, BEATS=1
    logic          b_ic_req_valid, b_ic_req_ready;
    logic [AW-1:0] b_ic_req_addr;
    logic          b_ic_resp_valid, b_ic_resp_last;
    logic          b_dc_req_valid, b_dc_req_ready, b_dc_req_rw;
    logic [AW-1:0] b_dc_req_addr;
    logic          b_dc_wdata_valid, b_dc_wdata_ready;
    logic [DW-1:0] b_dc_wdata;
    logic [MW-1:0] b_dc_wmask;
    logic          b_dc_resp_valid, b_dc_resp_last;
    logic [DW-1:0] b_resp_data;
    logic          b_mem_req_valid, b_mem_req_ready, b_mem_req_rw;
    logic [AW-1:0] b_mem_req_addr;
    logic          b_mem_req_data_valid, b_mem_req_data_ready;
    logic [DW-1:0] b_mem_req_data_bits;
    logic [MW-1:0] b_mem_req_data_mask;
    logic          b_mem_resp_valid;
    logic [DW-1:0] b_mem_resp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_wmask(dc_wmask), .dc_resp_valid(dc_resp_valid),
        .dc_resp_last(dc_resp_last), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .ic_req_valid(b_ic_req_valid), .ic_req_ready(b_ic_req_ready), .ic_req_addr(b_ic_req_addr),
        .ic_resp_valid(b_ic_resp_valid), .ic_resp_last(b_ic_resp_last),
        .dc_req_valid(b_dc_req_valid), .dc_req_ready(b_dc_req_ready), .dc_req_rw(b_dc_req_rw),
        .dc_req_addr(b_dc_req_addr), .dc_wdata_valid(b_dc_wdata_valid),
        .dc_wdata_ready(b_dc_wdata_ready), .dc_wdata(b_dc_wdata), .dc_wmask(b_dc_wmask),
        .dc_resp_valid(b_dc_resp_valid), .dc_resp_last(b_dc_resp_last), .resp_data(b_resp_data),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
        .mem_req_rw(b_mem_req_rw), .mem_req_addr(b_mem_req_addr),
        .mem_req_data_valid(b_mem_req_data_valid), .mem_req_data_ready(b_mem_req_data_ready),
        .mem_req_data_bits(b_mem_req_data_bits), .mem_req_data_mask(b_mem_req_data_mask),
        .mem_resp_valid(b_mem_resp_valid), .mem_resp_data(b_mem_resp_data)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       ic_v;
        logic       mrdy;
        logic       mrv;
        logic [7:0] md;
        logic       e_icr;
        logic       e_mqv;
        logic       e_irv;
        logic       e_irl;
        logic       e_drv;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [10];

    // Issue a read already granted; memory accepts at once, then 4 beats base..base+3
    task automatic serve_read(input logic exp_d, input logic [7:0] base, input logic [AW-1:0] exp_addr,
                              input logic keep_ic, input logic keep_dc);
        @(negedge clk);
        ic_req_valid = keep_ic; dc_req_valid = keep_dc;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        #1;
        chk("rd_req_valid", mem_req_valid, 1);
        chk("rd_req_rw", mem_req_rw, 0);
        chk("rd_req_addr", mem_req_addr, exp_addr);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
            mem_resp_data = DW'(base + 8'(b));
            #1;
            chk("rd_ic_valid", ic_resp_valid, !exp_d);
            chk("rd_dc_valid", dc_resp_valid, exp_d);
            chk("rd_ic_last", ic_resp_last, (!exp_d) && (b == 3));
            chk("rd_dc_last", dc_resp_last, exp_d && (b == 3));
            chk("rd_data", resp_data, DW'(base + 8'(b)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] arb_addr;
        logic          exp_arb [3];
        logic          tog;
        int            k;

        reset_n = 1'b0;
        ic_req_valid = 0; ic_req_addr = 28'h100;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0; dc_wmask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 1; mem_resp_data = DW'(8'h77);
        b_ic_req_valid = 0; b_ic_req_addr = '0;
        b_dc_req_valid = 0; b_dc_req_rw = 0; b_dc_req_addr = 28'h4C0;
        b_dc_wdata_valid = 0; b_dc_wdata = '0; b_dc_wmask = '0;
        b_mem_req_ready = 0; b_mem_req_data_ready = 0;
        b_mem_resp_valid = 0; b_mem_resp_data = '0;

        // Table for the first I-side read: addr 0x100, memory ready after 2 cycles
        //             ic_v mrdy mrv md      icr mqv irv irl drv rd
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA2};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ic_ready", ic_req_ready, 0);
        chk("rst_dc_ready", dc_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_req_rw", mem_req_rw, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_ic_resp_valid", ic_resp_valid, 0);
        chk("rst_dc_resp_valid", dc_resp_valid, 0);
        chk("rst_wdata_valid", mem_req_data_valid, 0);
        chk("rst_wdata_ready", dc_wdata_ready, 0);
        @(negedge clk);
        reset_n = 1'b1; mem_resp_valid = 0; mem_resp_data = '0;

        // Table-driven I read
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ic_req_valid = vecs[i].ic_v;
            mem_req_ready = vecs[i].mrdy;
            mem_resp_valid = vecs[i].mrv;
            mem_resp_data = DW'(vecs[i].md);
            #1;
            chk("tbl_ic_ready", ic_req_ready, vecs[i].e_icr);
            chk("tbl_dc_ready", dc_req_ready, 0);
            chk("tbl_mem_req_valid", mem_req_valid, vecs[i].e_mqv);
            chk("tbl_ic_resp_valid", ic_resp_valid, vecs[i].e_irv);
            chk("tbl_ic_resp_last", ic_resp_last, vecs[i].e_irl);
            chk("tbl_dc_resp_valid", dc_resp_valid, vecs[i].e_drv);
            chk("tbl_resp_data", resp_data, DW'(vecs[i].e_rd));
            if (vecs[i].e_mqv) begin
                chk("tbl_mem_req_addr", mem_req_addr, 28'h100);
                chk("tbl_mem_req_rw", mem_req_rw, 0);
            end
        end

        // D write 0x2A0, memory data ready toggling, stray response beat in WDATA
        @(negedge clk);
        mem_resp_valid = 0; mem_req_ready = 0;
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h2A0;
        #1;
        chk("wr_dc_ready", dc_req_ready, 1);
        chk("wr_ic_ready", ic_req_ready, 0);
        @(negedge clk);
        dc_req_valid = 0; mem_req_ready = 1;
        #1;
        chk("wr_req_valid", mem_req_valid, 1);
        chk("wr_req_addr", mem_req_addr, 28'h2A0);
        chk("wr_req_rw", mem_req_rw, 1);
        k = 0; tog = 1'b1;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            @(negedge clk);
            mem_req_ready = 0;
            mem_req_data_ready = tog; tog = !tog;
            dc_wdata_valid = 1; dc_wdata = {16{8'hB0 + 8'(k)}}; dc_wmask = 16'hFFFF;
            mem_resp_valid = (cyc == 1);
            #1;
            chk("wr_wdata_ready", dc_wdata_ready, mem_req_data_ready);
            chk("wr_data_valid", mem_req_data_valid, 1);
            chk("wr_data_bits", mem_req_data_bits, {16{8'hB0 + 8'(k)}});
            chk("wr_data_mask", mem_req_data_mask, DW'(16'hFFFF));
            chk("wr_stray_dc", dc_resp_valid, 0);
            chk("wr_stray_ic", ic_resp_valid, 0);
            if (mem_req_data_ready && dc_wdata_ready) k++;
        end
        chk("wr_beats", k, 4);
        @(negedge clk);
        mem_resp_valid = 0; mem_req_data_ready = 1;
        #1;
        chk("wr_idle_data_valid", mem_req_data_valid, 0);
        chk("wr_idle_wready", dc_wdata_ready, 0);
        dc_wdata_valid = 0; mem_req_data_ready = 0;

        // Both sides requesting every cycle for 3 transactions
`ifdef ARB_RR_EN
        exp_arb[0] = 1'b0; exp_arb[1] = 1'b1; exp_arb[2] = 1'b0;
`else
        exp_arb[0] = 1'b1; exp_arb[1] = 1'b1; exp_arb[2] = 1'b1;
`endif
        ic_req_addr = 28'h140; dc_req_addr = 28'h2C0; dc_req_rw = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            ic_req_valid = 1; dc_req_valid = 1; mem_resp_valid = 0;
            #1;
            chk("arb_dc_ready", dc_req_ready, exp_arb[t]);
            chk("arb_ic_ready", ic_req_ready, !exp_arb[t]);
            arb_addr = exp_arb[t] ? 28'h2C0 : 28'h140;
            serve_read(exp_arb[t], 8'h10 + 8'(t * 16), arb_addr, 1'b1, 1'b1);
        end

        // Reset asserted mid-read after 2 of 4 beats
        @(negedge clk);
        ic_req_valid = 0; dc_req_valid = 0; mem_resp_valid = 0;
        @(negedge clk);
        ic_req_valid = 1; ic_req_addr = 28'h340;
        #1;
        chk("mid_ic_ready", ic_req_ready, 1);
        @(negedge clk);
        ic_req_valid = 0; mem_req_ready = 1;
        #1;
        chk("mid_req_valid", mem_req_valid, 1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = DW'(8'hC0 + 8'(b));
            #1;
            chk("mid_ic_valid", ic_resp_valid, 1);
        end
        @(negedge clk);
        reset_n = 0; mem_resp_data = DW'(8'hC2);
        #1;
        chk("mid_rst_ic_valid", ic_resp_valid, 0);
        chk("mid_rst_ic_last", ic_resp_last, 0);
        chk("mid_rst_req_valid", mem_req_valid, 0);
        chk("mid_rst_resp_data", resp_data, 0);
        chk("mid_rst_addr", mem_req_addr, 0);
        @(negedge clk);
        reset_n = 1; mem_resp_data = DW'(8'hC3);
        #1;
        chk("mid_post_ic_valid", ic_resp_valid, 0);
        chk("mid_post_ic_last", ic_resp_last, 0);
        chk("mid_post_resp_data", resp_data, 0);
        @(negedge clk);
        mem_resp_valid = 0; ic_req_valid = 1; ic_req_addr = 28'h380;
        #1;
        chk("mid_next_ic_ready", ic_req_ready, 1);
        serve_read(1'b0, 8'hD0, 28'h380, 1'b0, 1'b0);
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        chk("mid_next_idle", mem_req_valid, 0);

        // BEATS=1 instance: single D read beat is also the last
        @(negedge clk);
        b_dc_req_valid = 1; b_dc_req_rw = 0;
        #1;
        chk("b1_dc_ready", b_dc_req_ready, 1);
        @(negedge clk);
        b_dc_req_valid = 0; b_mem_req_ready = 1;
        #1;
        chk("b1_req_valid", b_mem_req_valid, 1);
        chk("b1_req_addr", b_mem_req_addr, 28'h4C0);
        @(negedge clk);
        b_mem_req_ready = 0; b_mem_resp_valid = 1; b_mem_resp_data = DW'(8'hE7);
        #1;
        chk("b1_dc_valid", b_dc_resp_valid, 1);
        chk("b1_dc_last", b_dc_resp_last, 1);
        chk("b1_ic_valid", b_ic_resp_valid, 0);
        chk("b1_data", b_resp_data, DW'(8'hE7));
        @(negedge clk);
        b_mem_resp_valid = 0; b_dc_req_valid = 1;
        #1;
        chk("b1_back_idle", b_dc_req_ready, 1);
        chk("b1_no_req", b_mem_req_valid, 0);
        @(negedge clk);
        b_dc_req_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
